rnd_bank_harvester: RTL and testbench

// - Reader/controller for the random-generator bank: drives the bank's freeze gate and address select,

---
 rtl/rnd_bank_harvester.sv | 130 +++++++++++++
 tb/tb_rnd_bank_harvester.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rnd_bank_harvester.sv
// Random-bank reader: freezes and samples one 16-bit generator word at a time, von Neumann
// debiases it into bytes, and delivers the bytes through a small valid/ready FIFO.
module rnd_bank_harvester #(
    parameter int RND_N      = 34,
    parameter int ADDR_W     = 6,
    parameter int SETTLE     = 2,
    parameter int RUN        = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              freeze_o,
    output logic [ADDR_W-1:0] addr_o,
    input  logic [15:0]       rnd_i,
    output logic [7:0]        byte_o,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, FREEZE, SAMPLE, DEBIAS, RELEASE} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [15:0]     word;
    logic [2:0]      k;
    logic [7:0]      acc;
    logic [2:0]      nbits;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [PTR_W:0]  count;

    logic [1:0]      pair;
    logic            bit_vld;
    logic [7:0]      acc_nxt;
    logic            byte_done, full, stall, push, pop;

    always_comb begin
        pair      = word[{k, 1'b0} +: 2];
        bit_vld   = pair[1] ^ pair[0];
        acc_nxt   = {pair[1], acc[7:1]};
        byte_done = (state == DEBIAS) && bit_vld && (nbits == 3'd7);
        // Fullness is judged on the pre-pop count, so a same-cycle pop never makes room.
        full      = (count == (PTR_W+1)'(FIFO_DEPTH));
        stall     = byte_done && full;
        push      = byte_done && !full;
        pop       = byte_valid && byte_ready;
    end

    assign busy       = (state != IDLE);
    assign byte_valid = (count != '0);
    assign byte_o     = byte_valid ? mem[rptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            freeze_o <= 1'b0;
            addr_o   <= '0;
            cnt      <= '0;
            word     <= '0;
            k        <= '0;
            acc      <= '0;
            nbits    <= '0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    state    <= FREEZE;
                    freeze_o <= 1'b1;
                    cnt      <= '0;
                end
                FREEZE: if (cnt == 4'(SETTLE - 1)) state <= SAMPLE;
                        else                       cnt   <= cnt + 4'd1;
                SAMPLE: begin
                    word     <= rnd_i;
                    k        <= '0;
                    freeze_o <= 1'b0;
                    state    <= DEBIAS;
                end
                DEBIAS: if (!stall) begin
                    if (bit_vld) begin
                        acc   <= acc_nxt;
                        nbits <= nbits + 3'd1;  // wraps to 0 as the byte is pushed
                    end
                    if (k == 3'd7) begin
                        state  <= RELEASE;
                        cnt    <= '0;
                        addr_o <= (addr_o == ADDR_W'(RND_N - 1)) ? '0 : addr_o + 1'b1;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                RELEASE: if (cnt == 4'(RUN - 1)) begin
                    if (en) begin
                        state    <= FREEZE;
                        freeze_o <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end else begin
                    cnt <= cnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= acc_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_rnd_bank_harvester.sv
// Bench for rnd_bank_harvester: a bank model feeds words, and a byte-level reference model
// rebuilt from each observed sample checks every byte handed over, plus the addressing and timing.
module tb_rnd_bank_harvester;
    localparam int RND_N  = 34;
    localparam int SETTLE = 2;
    localparam int RUN    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        freeze_o;
    logic [5:0]  addr_o;
    logic [15:0] rnd_i;
    logic [7:0]  byte_o;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;

    rnd_bank_harvester #(.RND_N(RND_N), .ADDR_W(6), .SETTLE(SETTLE), .RUN(RUN), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .freeze_o(freeze_o), .addr_o(addr_o),
        .rnd_i(rnd_i), .byte_o(byte_o), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bank model and consumer controls
    int          mode = 0;           // 0 fixed wa, 1 alternate wa/wb per sample, 2 random
    logic [15:0] wa = 16'h0, wb = 16'h0;
    bit          alt_sel = 1'b0;
    bit          rand_rdy = 1'b0;
    bit          man_rdy = 1'b0;

    initial begin
        rnd_i = 16'h0;
        byte_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            // The bank only changes its outputs while not frozen.
            if (!freeze_o) begin
                case (mode)
                    0:       rnd_i = wa;
                    1:       rnd_i = alt_sel ? wb : wa;
                    default: rnd_i = 16'($urandom);
                endcase
            end
            byte_ready = rand_rdy ? 1'($urandom_range(0, 1)) : man_rdy;
        end
    end

    // Reference model: words observed at sample time, turned into bytes by the debias rule.
    logic [7:0]  q[$];
    logic [7:0]  accm = 8'h0;
    int          nb = 0;
    int          exp_addr = 0;
    int          samples = 0;
    int          cyc = 0, last_cyc = 0, last_gap = 0;
    int          frun = 0;
    bit          prev_f = 1'b0;
    logic [15:0] prev_rnd = 16'h0;
    logic [5:0]  prev_addr = 6'h0;

    task automatic model_word(input logic [15:0] w);
        logic [1:0] pr;
        for (int p = 0; p < 8; p++) begin
            pr = w[2*p +: 2];
            if (pr == 2'b10 || pr == 2'b01) begin
                if (pr == 2'b10) accm[nb] = 1'b1;
                nb++;
                if (nb == 8) begin
                    q.push_back(accm);
                    accm = 8'h0;
                    nb = 0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            accm = 8'h0; nb = 0; exp_addr = 0; frun = 0;
            prev_f = 1'b0; prev_addr = 6'h0; alt_sel = 1'b0;
        end else begin
            if (byte_valid && byte_ready) begin
                if (q.size() == 0) check("pop_model_nonempty", 32'(q.size()), 32'd1);
                else               check("pop_byte", 32'(byte_o), 32'(q.pop_front()));
            end
            if (freeze_o) begin
                frun++;
                check("addr_stable_frozen", 32'(addr_o), 32'(prev_addr));
            end
            if (prev_f && !freeze_o) begin
                check("freeze_len", frun, SETTLE + 1);
                check("sample_addr", 32'(addr_o), exp_addr);
                exp_addr = (exp_addr + 1) % RND_N;
                model_word(prev_rnd);
                samples++;
                last_gap = cyc - last_cyc;
                last_cyc = cyc;
                alt_sel = ~alt_sel;
                frun = 0;
            end
            prev_f = freeze_o;
            prev_rnd = rnd_i;
            prev_addr = addr_o;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && !byte_valid; i++) step(1);
        check(tag, 32'(byte_valid), 32'd1);
    endtask

    task automatic wait_samples(input string tag, input int n, input int budget);
        int target;
        target = samples + n;
        for (int i = 0; i < budget && samples < target; i++) step(1);
        check(tag, 32'(samples >= target), 32'd1);
    endtask

    int s0, n;

    initial begin
        // Reset state
        @(posedge clk); @(posedge clk);
        @(negedge clk); #1;
        check("rst_freeze", 32'(freeze_o), 0);
        check("rst_addr", 32'(addr_o), 0);
        check("rst_valid", 32'(byte_valid), 0);
        check("rst_byte", 32'(byte_o), 0);
        check("rst_busy", 32'(busy), 0);
        do_reset();

        // 0xAAAA gives eight 1s per word
        mode = 0; wa = 16'hAAAA; man_rdy = 1'b0; en = 1'b1;
        wait_valid("t1_valid", 60);
        check("t1_first_byte", 32'(byte_o), 32'hFF);
        man_rdy = 1'b1;
        step(40);

        // 0x000A then 0x5555: two 1s then six 0s
        do_reset();
        mode = 1; wa = 16'h000A; wb = 16'h5555; man_rdy = 1'b0; en = 1'b1;
        wait_valid("t2_valid", 60);
        check("t2_first_byte", 32'(byte_o), 32'h03);
        man_rdy = 1'b1;
        step(20);

        // Constant words yield no bits, but the bank keeps being scanned every 15 cycles
        do_reset();
        mode = 0; wa = 16'h0000; man_rdy = 1'b1; en = 1'b1;
        wait_samples("t3_samples0", 4, 100);
        check("t3_gap", last_gap, SETTLE + 1 + 8 + RUN);
        check("t3_no_valid0", 32'(byte_valid), 0);
        wa = 16'hFFFF;
        wait_samples("t3_samplesF", 3, 100);
        check("t3_no_valid1", 32'(byte_valid), 0);
        check("t3_gapF", last_gap, 15);

        // FIFO full: fifth byte stalls DEBIAS, then drains with nothing lost
        do_reset();
        s0 = samples;
        mode = 0; wa = 16'hAAAA; man_rdy = 1'b0; en = 1'b1;
        step(100);
        check("t5_samples", samples - s0, 5);
        check("t5_valid", 32'(byte_valid), 1);
        check("t5_busy", 32'(busy), 1);
        check("t5_freeze", 32'(freeze_o), 0);
        step(30);
        check("t5_held", samples - s0, 5);
        check("t5_busy_held", 32'(busy), 1);
        man_rdy = 1'b1;
        wait_samples("t5_resume", 2, 80);

        // Drop en during DEBIAS: word finishes, IDLE after RUN cycles
        wait_samples("t6_sample", 1, 40);
        en = 1'b0;
        s0 = samples;
        n = 0;
        while (busy && n < 40) begin step(1); n++; end
        check("t6_cycles_to_idle", n, 8 + RUN);
        check("t6_freeze", 32'(freeze_o), 0);
        step(20);
        check("t6_no_sample", samples - s0, 0);
        check("t6_idle", 32'(busy), 0);

        // Reset in the middle of DEBIAS
        en = 1'b1;
        wait_samples("t7_sample", 1, 40);
        step(2);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        check("t7_freeze", 32'(freeze_o), 0);
        check("t7_addr", 32'(addr_o), 0);
        check("t7_valid", 32'(byte_valid), 0);
        check("t7_byte", 32'(byte_o), 0);
        check("t7_busy", 32'(busy), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Random words, random back-pressure, across the address wrap
        mode = 2; rand_rdy = 1'b1; en = 1'b1;
        wait_samples("t8_wrap", 37, 37 * 15 * 4);
        en = 1'b0;
        rand_rdy = 1'b0; man_rdy = 1'b1;
        n = 0;
        while ((busy || byte_valid) && n < 200) begin step(1); n++; end
        check("t8_idle", 32'(busy), 0);
        check("t8_drained", 32'(byte_valid), 0);
        check("t8_model_empty", 32'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
